// File: rtl/exe_mem_pkg.sv
// Shared types and constants for the EXE->MEM boundary register.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package exe_mem_pkg;

  // Number of control bits at the top of every payload word.
  localparam int CTRL_BITS = 3;

  // Default field widths, matching the top-level parameter defaults.
  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEST_W = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

  // Payload layout at default widths. The control bits sit in the MSBs so
  // an entry can clear them with a fixed slice. The top re-declares this
  // same layout sized by its own DATA_W/DEST_W parameters.
  typedef struct packed {
    logic                  wb_en;
    logic                  mem_read_en;
    logic                  mem_write_en;
    logic [DEF_DATA_W-1:0] alu_res;
    logic [DEF_DATA_W-1:0] val_rm;
    logic [DEF_DEST_W-1:0] dest;
  } exe_mem_payload_t;

endpackage

// File: rtl/exe_mem_entry.sv
// One payload holding register with load, control-bit clear and async reset.
// Latency: d appears on q one cycle after load.
// Backpressure: none; the owner decides when to load.
//
// Ports: clk, rst (async, active-high), load, clr_ctrl, d[W-1:0], q[W-1:0].
// clr_ctrl wins over load and only zeroes the control slice; the rest of the
// payload keeps its stale value because the owner masks it by valid.
module exe_mem_entry
  import exe_mem_pkg::*;
#(
  parameter int W = CTRL_BITS + 2 * DEF_DATA_W + DEF_DEST_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clr_ctrl,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr_ctrl) begin
      q[W-1 -: CTRL_BITS] <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/exe_mem_skid_reg.sv
// EXE->MEM pipeline register with one-entry skid buffer, flush and stall counter.
// Latency: one cycle from acceptance to out_*; one beat per cycle sustained.
// Backpressure: in_ready is registered (low only when both entries are held).
//
// Ports:
//   clk, rst (async, active-high), flush (sync kill of held beats)
//   in_valid/in_ready + in_wb_en, in_mem_read_en, in_mem_write_en,
//     in_alu_res, in_val_rm, in_dest            -- EXE side
//   out_valid/out_ready + out_wb_en, out_mem_read_en, out_mem_write_en,
//     out_alu_res, out_val_rm, out_dest         -- MEM side
//   stall_cnt -- saturating count of cycles with out_valid & ~out_ready
module exe_mem_skid_reg
  import exe_mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEST_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_wb_en,
  input  logic              in_mem_read_en,
  input  logic              in_mem_write_en,
  input  logic [DATA_W-1:0] in_alu_res,
  input  logic [DATA_W-1:0] in_val_rm,
  input  logic [DEST_W-1:0] in_dest,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_wb_en,
  output logic              out_mem_read_en,
  output logic              out_mem_write_en,
  output logic [DATA_W-1:0] out_alu_res,
  output logic [DATA_W-1:0] out_val_rm,
  output logic [DEST_W-1:0] out_dest,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int PW = CTRL_BITS + 2 * DATA_W + DEST_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic              wb_en;
    logic              mem_read_en;
    logic              mem_write_en;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] val_rm;
    logic [DEST_W-1:0] dest;
  } payload_t;

  skid_state_t state_q, state_d;
  payload_t    in_pl, main_q, skid_q, main_d;
  logic        accept, drain;
  logic        main_load, skid_load, main_from_skid;

  assign in_pl = '{wb_en:        in_wb_en,
                   mem_read_en:  in_mem_read_en,
                   mem_write_en: in_mem_write_en,
                   alu_res:      in_alu_res,
                   val_rm:       in_val_rm,
                   dest:         in_dest};

  // in_ready depends only on the state register, so out_ready never reaches
  // it combinationally; the skid entry absorbs the one beat in flight.
  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid & in_ready & ~flush;
  assign drain     = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    skid_load      = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d   = BUSY;
            main_load = 1'b1;
          end
        end
        BUSY: begin
          if (accept && drain) begin
            main_load = 1'b1;
          end else if (accept) begin
            state_d   = FULL;
            skid_load = 1'b1;
          end else if (drain) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (drain) begin
            state_d        = BUSY;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  assign main_d = main_from_skid ? skid_q : in_pl;

  exe_mem_entry #(.W(PW)) u_main (
    .clk      (clk),
    .rst      (rst),
    .load     (main_load),
    .clr_ctrl (flush),
    .d        (main_d),
    .q        (main_q)
  );

  exe_mem_entry #(.W(PW)) u_skid (
    .clk      (clk),
    .rst      (rst),
    .load     (skid_load),
    .clr_ctrl (flush),
    .d        (in_pl),
    .q        (skid_q)
  );

  // Control bits are gated by out_valid so a bubble can never write.
  assign out_wb_en        = main_q.wb_en & out_valid;
  assign out_mem_read_en  = main_q.mem_read_en & out_valid;
  assign out_mem_write_en = main_q.mem_write_en & out_valid;
  assign out_alu_res      = main_q.alu_res;
  assign out_val_rm       = main_q.val_rm;
  assign out_dest         = main_q.dest;

  // Flush deliberately leaves the counter alone; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && stall_cnt != CNT_MAX) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_exe_mem_skid_reg.sv
// Self-checking bench for exe_mem_skid_reg: directed scenarios then random
// traffic, all compared against a queue-based model of the held beats.
// Inputs change 1 time unit after posedge; outputs are compared at negedge.
module tb_exe_mem_skid_reg;

  localparam int DW = 32;
  localparam int RW = 4;
  localparam int CW = 4;
  localparam int CMAX = 15;

  typedef struct packed {
    logic          wb;
    logic          rd;
    logic          wr;
    logic [DW-1:0] alu;
    logic [DW-1:0] rm;
    logic [RW-1:0] dest;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  beat_t in_b = '0;

  logic          in_ready, out_valid;
  logic          out_wb_en, out_mem_read_en, out_mem_write_en;
  logic [DW-1:0] out_alu_res, out_val_rm;
  logic [RW-1:0] out_dest;
  logic [CW-1:0] stall_cnt;

  exe_mem_skid_reg #(.DATA_W(DW), .DEST_W(RW), .CNT_W(CW)) dut (
    .clk              (clk),
    .rst              (rst),
    .flush            (flush),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_wb_en         (in_b.wb),
    .in_mem_read_en   (in_b.rd),
    .in_mem_write_en  (in_b.wr),
    .in_alu_res       (in_b.alu),
    .in_val_rm        (in_b.rm),
    .in_dest          (in_b.dest),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_wb_en        (out_wb_en),
    .out_mem_read_en  (out_mem_read_en),
    .out_mem_write_en (out_mem_write_en),
    .out_alu_res      (out_alu_res),
    .out_val_rm       (out_val_rm),
    .out_dest         (out_dest),
    .stall_cnt        (stall_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: beats currently held, oldest first, and stall count.
  beat_t mq[$];
  int    m_cnt = 0;
  int    n_chk = 0;
  int    n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic check_outputs();
    beat_t h;
    chk("out_valid", 64'(out_valid), 64'(mq.size() > 0));
    chk("in_ready", 64'(in_ready), 64'(mq.size() < 2));
    chk("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
    if (mq.size() > 0) begin
      h = mq[0];
      chk("out_alu_res", 64'(out_alu_res), 64'(h.alu));
      chk("out_val_rm", 64'(out_val_rm), 64'(h.rm));
      chk("out_dest", 64'(out_dest), 64'(h.dest));
      chk("out_ctrl", 64'({out_wb_en, out_mem_read_en, out_mem_write_en}),
          64'({h.wb, h.rd, h.wr}));
    end else begin
      chk("bubble_ctrl", 64'({out_wb_en, out_mem_read_en, out_mem_write_en}), 64'(0));
    end
  endtask

  // One clock: compare at negedge, then advance the model at posedge.
  task automatic cycle();
    bit acc, drn, stl;
    @(negedge clk);
    check_outputs();
    acc = in_valid && (mq.size() < 2) && !flush;
    drn = (mq.size() > 0) && out_ready;
    stl = (mq.size() > 0) && !out_ready;
    @(posedge clk);
    if (stl && m_cnt < CMAX) m_cnt++;
    if (flush) begin
      mq.delete();
    end else begin
      if (drn) void'(mq.pop_front());
      if (acc) mq.push_back(in_b);
    end
    #1;
  endtask

  function automatic beat_t mk(input logic [DW-1:0] alu, input logic [RW-1:0] dest,
                               input logic wb, input logic wr);
    beat_t b;
    b = '0;
    b.alu  = alu;
    b.rm   = alu ^ 32'h5A5A_0000;
    b.dest = dest;
    b.wb   = wb;
    b.wr   = wr;
    return b;
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset values, including payload.
    @(negedge clk);
    check_outputs();
    chk("rst_alu", 64'(out_alu_res), 64'(0));
    chk("rst_rm", 64'(out_val_rm), 64'(0));
    chk("rst_dest", 64'(out_dest), 64'(0));
    @(posedge clk);
    #1;

    // Single beat.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_b      = mk(32'h0000_1234, 4'd5, 1'b1, 1'b0);
    cycle();
    in_valid = 1'b0;
    cycle();
    cycle();

    // Streaming eight beats back to back.
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_b     = mk(32'(i), 4'(i), 1'b1, 1'b0);
      cycle();
    end
    in_valid = 1'b0;
    repeat (2) cycle();
    chk("stream_stall", 64'(stall_cnt), 64'(0));

    // A and B under back-pressure, then release.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_b      = mk(32'hA, 4'd1, 1'b1, 1'b0);
    cycle();
    in_b = mk(32'hB, 4'd2, 1'b0, 1'b1);
    cycle();
    in_b = mk(32'hD, 4'd3, 1'b1, 1'b1);   // offered while FULL, must wait
    cycle();
    in_valid = 1'b0;
    cycle();
    out_ready = 1'b1;
    repeat (3) cycle();

    // Flush while FULL with a concurrent input beat C.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_b      = mk(32'h100, 4'd6, 1'b0, 1'b1);
    cycle();
    in_b = mk(32'h200, 4'd7, 1'b0, 1'b1);
    cycle();
    in_valid = 1'b0;
    cycle();
    flush    = 1'b1;
    in_valid = 1'b1;
    in_b     = mk(32'hC, 4'd8, 1'b1, 1'b1);
    cycle();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("flush_vld", 64'(out_valid), 64'(0));
    chk("flush_wr", 64'(out_mem_write_en), 64'(0));
    chk("flush_rdy", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;
    repeat (2) cycle();

    // Saturation of the stall counter, then flush must not touch it.
    in_valid = 1'b1;
    in_b     = mk(32'h77, 4'd9, 1'b1, 1'b0);
    out_ready = 1'b0;
    cycle();
    in_valid = 1'b0;
    repeat (20) cycle();
    chk("sat_cnt", 64'(stall_cnt), 64'(CMAX));
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    cycle();
    chk("sat_after_flush", 64'(stall_cnt), 64'(CMAX));

    // Asynchronous reset while FULL, checked before the next edge.
    in_valid = 1'b1;
    in_b     = mk(32'hE1, 4'd10, 1'b1, 1'b1);
    cycle();
    in_b = mk(32'hE2, 4'd11, 1'b1, 1'b1);
    cycle();
    in_valid = 1'b0;
    cycle();
    #2 rst = 1'b1;
    #1;
    chk("arst_vld", 64'(out_valid), 64'(0));
    chk("arst_rdy", 64'(in_ready), 64'(1));
    chk("arst_ctrl", 64'({out_wb_en, out_mem_read_en, out_mem_write_en}), 64'(0));
    chk("arst_cnt", 64'(stall_cnt), 64'(0));
    mq.delete();
    m_cnt = 0;
    @(posedge clk);
    #1 rst = 1'b0;

    // Random traffic: lighter drain first to exercise FULL, then heavier.
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 99) < (i < 200 ? 40 : 75));
      flush     = ($urandom_range(0, 15) == 0);
      in_b.wb   = 1'($urandom_range(0, 1));
      in_b.rd   = 1'($urandom_range(0, 1));
      in_b.wr   = 1'($urandom_range(0, 1));
      in_b.alu  = $urandom;
      in_b.rm   = $urandom;
      in_b.dest = 4'($urandom_range(0, 15));
      cycle();
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (3) cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
